// File: rtl/dcm_ramp_ctrl.sv
// dcm_ramp_ctrl: duty-ramp controller for a DC motor channel, with direction reversal through a coast dwell.
// Ports:
//   clk, rst_n (async active-low)    : clock and reset
//   cmd_valid/cmd_ready              : command handshake; cmd_dir, cmd_duty, cmd_step, cmd_coast carry the target
//   tick                             : ramp update strobe
//   estop                            : level-sensitive emergency stop
//   dir, coast, pwm_duty             : registered motor channel outputs
//   busy, done                       : status; done pulses only when built with DCM_RAMP_DONE_EN
// Optional feature macro: DCM_RAMP_DONE_EN (enables the done pulse; otherwise done stays 0).
module dcm_ramp_ctrl #(
   parameter int DUTY_W       = 16,
   parameter int DWELL_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [DUTY_W-1:0] cmd_duty,
   input  logic [DUTY_W-1:0] cmd_step,
   input  logic              cmd_coast,
   input  logic              tick,
   input  logic              estop,
   output logic              dir,
   output logic              coast,
   output logic [DUTY_W-1:0] pwm_duty,
   output logic              busy,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, RAMP, DWELL, STOP} state_t;
   localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
   state_t            state_q, state_d;
   logic              dir_q, dir_d, coast_q, coast_d, tgt_dir_q, tgt_dir_d;
   logic              busy_q, busy_d, done_q, done_d, ready_q, ready_d;
   logic [DUTY_W-1:0] duty_q, duty_d, tgt_duty_q, tgt_duty_d, step_q, step_d;
   logic [15:0]       dwell_q, dwell_d;
   logic              accept;
   logic [DUTY_W-1:0] rev_duty, up_duty, dn_duty;
   assign accept = cmd_valid & ready_q;
   // Saturating moves: a step of 0 or a step at least as large as the gap lands exactly on the target.
   assign rev_duty = (step_q == '0 || duty_q <= step_q) ? '0 : duty_q - step_q;
   assign up_duty  = (step_q == '0 || tgt_duty_q - duty_q <= step_q) ? tgt_duty_q : duty_q + step_q;
   assign dn_duty  = (step_q == '0 || duty_q - tgt_duty_q <= step_q) ? tgt_duty_q : duty_q - step_q;
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      coast_d    = coast_q;
      duty_d     = duty_q;
      tgt_dir_d  = tgt_dir_q;
      tgt_duty_d = tgt_duty_q;
      step_d     = step_q;
      dwell_d    = dwell_q;
      done_d     = 1'b0;
      if (estop) begin
         state_d    = STOP;
         duty_d     = '0;
         coast_d    = 1'b1;
         tgt_duty_d = '0;
      end else begin
         case (state_q)
            IDLE, RAMP: begin
               if (accept && cmd_coast) begin
                  state_d    = IDLE;
                  tgt_dir_d  = dir_q;
                  tgt_duty_d = '0;
                  step_d     = cmd_step;
                  duty_d     = '0;
                  coast_d    = 1'b1;
               end else if (accept) begin
                  state_d    = RAMP;
                  tgt_dir_d  = cmd_dir;
                  tgt_duty_d = cmd_duty;
                  step_d     = cmd_step;
                  coast_d    = 1'b0;
               end else if (state_q == RAMP) begin
                  if (tgt_dir_q != dir_q) begin
                     // Reversal: ramp to zero first, then coast through the dwell before flipping dir.
                     if (duty_q == '0 || (tick && rev_duty == '0)) begin
                        duty_d  = '0;
                        coast_d = 1'b1;
                        dwell_d = '0;
                        state_d = DWELL;
                     end else if (tick) begin
                        duty_d = rev_duty;
                     end
                  end else if (duty_q == tgt_duty_q) begin
                     state_d = IDLE;
`ifdef DCM_RAMP_DONE_EN
                     done_d  = 1'b1;
`else
                     done_d  = 1'b0;
`endif
                  end else if (tick) begin
                     duty_d = (tgt_duty_q > duty_q) ? up_duty : dn_duty;
                  end
               end
            end
            DWELL: begin
               dwell_d = dwell_q + 16'd1;
               if (dwell_q == DWELL_LAST) begin
                  dwell_d = '0;
                  dir_d   = tgt_dir_q;
                  coast_d = 1'b0;
                  state_d = RAMP;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d  = state_d != IDLE;
      ready_d = state_d == IDLE || state_d == RAMP;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dir_q      <= 1'b0;
         coast_q    <= 1'b1;
         duty_q     <= '0;
         tgt_dir_q  <= 1'b0;
         tgt_duty_q <= '0;
         step_q     <= '0;
         dwell_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         coast_q    <= coast_d;
         duty_q     <= duty_d;
         tgt_dir_q  <= tgt_dir_d;
         tgt_duty_q <= tgt_duty_d;
         step_q     <= step_d;
         dwell_q    <= dwell_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
      end
   end
   assign cmd_ready = ready_q;
   assign dir       = dir_q;
   assign coast     = coast_q;
   assign pwm_duty  = duty_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_dcm_ramp_ctrl.sv
// tb_dcm_ramp_ctrl: directed self-checking bench for dcm_ramp_ctrl.
module tb_dcm_ramp_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_coast = 1'b0, tick = 1'b0, estop = 1'b0;
   logic [15:0] cmd_duty = '0, cmd_step = '0;
   logic        cmd_ready, dir, coast, busy, done;
   logic [15:0] pwm_duty;
   int          total = 0, bad = 0;
`ifdef DCM_RAMP_DONE_EN
   localparam logic DONE_EXP = 1'b1;
`else
   localparam logic DONE_EXP = 1'b0;
`endif
   dcm_ramp_ctrl #(.DUTY_W(16), .DWELL_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .cmd_step(cmd_step), .cmd_coast(cmd_coast),
      .tick(tick), .estop(estop), .dir(dir), .coast(coast), .pwm_duty(pwm_duty),
      .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic cmd(input logic d, input logic [15:0] duty, input logic [15:0] step, input logic c);
      cmd_valid = 1'b1; cmd_dir = d; cmd_duty = duty; cmd_step = step; cmd_coast = c;
      cyc();
      cmd_valid = 1'b0; cmd_coast = 1'b0;
   endtask
   task automatic do_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask
   initial begin
      logic [15:0] ramp_exp [4];
      ramp_exp = '{16'd30, 16'd60, 16'd90, 16'd100};
      #12;
      chk("rst_dir", dir, 0);
      chk("rst_coast", coast, 1);
      chk("rst_duty", pwm_duty, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_done", done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("ready_before_edge", cmd_ready, 0);
      cyc();
      chk("ready_after_release", cmd_ready, 1);
      // ramp up 0 -> 100 by 30; the tick on the accept edge is ignored
      tick = 1'b1;
      cmd(1'b0, 16'd100, 16'd30, 1'b0);
      tick = 1'b0;
      chk("acc_duty", pwm_duty, 0);
      chk("acc_busy", busy, 1);
      chk("acc_coast", coast, 0);
      for (int i = 0; i < 4; i++) begin
         do_tick();
         chk("ramp_up", pwm_duty, ramp_exp[i]);
      end
      chk("done_early", done, 0);
      cyc();
      chk("done_pulse", done, DONE_EXP);
      chk("idle_busy", busy, 0);
      cyc();
      chk("done_clear", done, 0);
      // reversal 100 (dir 0) -> 50 (dir 1) step 50
      cmd(1'b1, 16'd50, 16'd50, 1'b0);
      do_tick();
      chk("rev_50", pwm_duty, 50);
      chk("rev_50_coast", coast, 0);
      do_tick();
      chk("rev_0", pwm_duty, 0);
      for (int i = 0; i < 8; i++) begin
         chk("dwell_coast", coast, 1);
         chk("dwell_dir", dir, 0);
         chk("dwell_ready", cmd_ready, 0);
         if (i == 1) begin
            cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_duty = 16'd7; cmd_step = 16'd1;
         end
         if (i == 3) cmd_valid = 1'b0;
         cyc();
      end
      chk("dwell_exit_dir", dir, 1);
      chk("dwell_exit_coast", coast, 0);
      chk("dwell_exit_busy", busy, 1);
      do_tick();
      chk("rev_final", pwm_duty, 50);
      cyc();
      chk("rev_idle", busy, 0);
      // estop at pwm_duty 60, colliding with an accept and a tick
      cmd(1'b1, 16'd90, 16'd10, 1'b0);
      do_tick();
      chk("pre_estop", pwm_duty, 60);
      estop = 1'b1; tick = 1'b1; cmd_valid = 1'b1; cmd_duty = 16'd200;
      cyc();
      tick = 1'b0; cmd_valid = 1'b0;
      chk("estop_duty", pwm_duty, 0);
      chk("estop_coast", coast, 1);
      chk("estop_ready", cmd_ready, 0);
      chk("estop_dir", dir, 1);
      cyc();
      chk("estop_hold", busy, 1);
      estop = 1'b0;
      cyc();
      chk("estop_idle", busy, 0);
      chk("estop_ready_back", cmd_ready, 1);
      chk("estop_done", done, 0);
      // reset mid-DWELL: reversal from duty 0 dwells immediately, no tick needed
      cmd(1'b0, 16'd20, 16'd5, 1'b0);
      cyc();
      chk("imm_dwell_coast", coast, 1);
      chk("imm_dwell_ready", cmd_ready, 0);
      cyc(); cyc();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", cmd_ready, 0);
      chk("mid_rst_coast", coast, 1);
      chk("mid_rst_dir", dir, 0);
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) cyc();
      chk("no_resume_busy", busy, 0);
      chk("no_resume_coast", coast, 1);
      chk("no_resume_dir", dir, 0);
      // step 0 jumps, large step does not wrap
      cmd(1'b0, 16'hFFFF, 16'd0, 1'b0);
      chk("jump_pre", pwm_duty, 0);
      do_tick();
      chk("jump_ffff", pwm_duty, 16'hFFFF);
      cyc();
      cmd(1'b0, 16'd5, 16'd0, 1'b0);
      do_tick();
      chk("jump_5", pwm_duty, 5);
      cyc();
      cmd(1'b0, 16'd0, 16'hFFFF, 1'b0);
      do_tick();
      chk("no_wrap", pwm_duty, 0);
      chk("zero_tgt_coast", coast, 0);
      cyc();
      chk("zero_tgt_idle", busy, 0);
      // coast command mid-ramp
      cmd(1'b0, 16'd40, 16'd10, 1'b0);
      do_tick();
      chk("pre_coast", pwm_duty, 10);
      cmd(1'b1, 16'd40, 16'd10, 1'b1);
      chk("coast_duty", pwm_duty, 0);
      chk("coast_flag", coast, 1);
      chk("coast_busy", busy, 0);
      chk("coast_done", done, 0);
      chk("coast_dir", dir, 0);
      cyc();
      chk("coast_done_after", done, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dcm_ramp_ctrl.md
DCM_RAMP_CTRL -- requirements
Module: dcm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DUTY_W, default 16, width of duty and step values.
REQ-002 SHALL have parameter DWELL_CYCLES, default 8, number of clk cycles to coast before a direction flip; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at posedge.
REQ-007 SHALL have port cmd_dir  input  1  target direction.
REQ-008 SHALL have port cmd_duty  input  DUTY_W  target duty.
REQ-009 SHALL have port cmd_step  input  DUTY_W  duty change per tick; 0 means jump.
REQ-010 SHALL have port cmd_coast  input  1  coast request; overrides cmd_duty and cmd_dir.
REQ-011 SHALL have port tick  input  1  one-cycle ramp update strobe.
REQ-012 SHALL have port estop  input  1  emergency stop, level sensitive.
REQ-013 SHALL have port dir  output  1  to motor channel dir.
REQ-014 SHALL have port coast  output  1  to motor channel coast.
REQ-015 SHALL have port pwm_duty  output  DUTY_W  to motor channel pwm_duty; zero-extended by the integrator.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a ramp reaches target (see Configuration).

Function
REQ-018 SHALL implement states IDLE, RAMP, DWELL and STOP, with all outputs registered.
REQ-019 cmd_ready SHALL be 1 in IDLE and RAMP and 0 in DWELL and STOP.
REQ-020 On accept, SHALL latch tgt_dir, tgt_duty and step; if cmd_coast=1, SHALL instead force tgt_duty=0, set pwm_duty=0 and coast=1 on the same edge, and go to IDLE.
REQ-021 A non-coast accept SHALL clear coast and go to RAMP; a later accept during RAMP SHALL replace the target.
REQ-022 A tick coinciding with the accept edge SHALL be ignored; the first duty change SHALL occur on the first tick after the accept.
REQ-023 In RAMP with tgt_dir==dir, each tick SHALL move pwm_duty toward tgt_duty by step, saturating exactly at tgt_duty, with no overshoot and no wrap-around at 0 or 2^DUTY_W-1.
REQ-024 In RAMP with tgt_dir!=dir, ticks SHALL ramp pwm_duty toward 0.
REQ-025 When the reversal ramp reaches 0 (including an immediate reach when pwm_duty is already 0), SHALL set coast=1 and enter DWELL.
REQ-026 DWELL SHALL last exactly DWELL_CYCLES clk cycles; on exit SHALL set dir=tgt_dir and coast=0, then return to RAMP.
REQ-027 A step of 0 SHALL set pwm_duty=tgt_duty on the next tick, still honouring REQ-024 through REQ-026 for reversals.
REQ-028 RAMP SHALL go to IDLE on the cycle after pwm_duty==tgt_duty and dir==tgt_dir.
REQ-029 Reaching the target SHALL leave coast=0 when tgt_duty==0 and the request was not a coast.
REQ-030 estop=1 SHALL, on the next edge and from any state, force pwm_duty=0, coast=1, tgt_duty=0 and state STOP.
REQ-031 STOP SHALL hold while estop=1 and SHALL go to IDLE one cycle after estop falls; dir SHALL be unchanged.
REQ-032 estop SHALL take priority over an accept and a tick in the same cycle.

Reset
REQ-033 While rst_n=0, SHALL asynchronously force state=IDLE, dir=0, coast=1, pwm_duty=0, busy=0, done=0, cmd_ready=0, tgt_duty=0, tgt_dir=0 and the dwell counter to 0.
REQ-034 cmd_ready SHALL rise on the first posedge after rst_n deasserts.
REQ-035 Reset asserted mid-ramp or mid-DWELL SHALL abandon the operation; the dwell counter SHALL not resume.

Configuration
REQ-036 With macro DCM_RAMP_DONE_EN defined, SHALL pulse done for exactly one cycle on the RAMP-to-IDLE transition, but not when leaving via estop or cmd_coast.
REQ-037 Without DCM_RAMP_DONE_EN, the done port SHALL remain present and tied to 0, with no other behaviour change.

Verification
REQ-038 SHALL cover: hold rst_n=0 -> dir=0, coast=1, pwm_duty=0, busy=0, cmd_ready=0; one posedge after release -> cmd_ready=1.
REQ-039 SHALL cover: accept dir=0, duty=100, step=30, then 4 ticks -> pwm_duty 30, 60, 90, 100, followed by a single done pulse (macro on).
REQ-040 SHALL cover: at dir=0, duty=100, accept dir=1, duty=50, step=50 -> ticks give 50 then 0; coast=1 for 8 cycles; then dir=1, coast=0; next tick gives 50.
REQ-041 SHALL cover: estop=1 while ramping at pwm_duty=60 -> next edge pwm_duty=0, coast=1, cmd_ready=0; release -> IDLE after 1 cycle.
REQ-042 SHALL cover: cmd_valid during DWELL -> not accepted; rst_n pulsed mid-DWELL -> REQ-033 values and no stale dir flip.
REQ-043 SHALL cover: step=0, duty=0xFFFF -> pwm_duty=0xFFFF on the first tick; step=0xFFFF ramping down from 5 -> 0 with no wrap.
